// File: rtl/pu_pkg.sv
// ---------------------------------------------------------------------------
// pu_pkg -- shared definitions for the processing-unit SEND DMA engine.
//
// Contents:
//   DW, AW, PW        default data, address/size and destination-port widths
//   send_dma_state_t  state encoding of the send_dma controller
//
// Build option: SEND_DMA_HDR_EN adds the HDR state. This state sends one
// header word before the payload.
// ---------------------------------------------------------------------------
package pu_pkg;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int PW = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    TX   = 3'd3,
    FIN  = 3'd4
`ifdef SEND_DMA_HDR_EN
    ,
    HDR  = 3'd5
`endif
  } send_dma_state_t;

endpackage

// File: rtl/send_dma_if.sv
// ---------------------------------------------------------------------------
// send_dma_if -- word stream from the SEND DMA engine to the interconnect.
//
// Signals:
//   tx_valid  word offered by the master
//   tx_data   payload word (DW bits)
//   tx_port   destination port (PW bits)
//   tx_last   marks the final word of a transfer
//   tx_ready  slave accepts the word when tx_valid and tx_ready are both high
//
// Modports: master (DMA side) and slave (interconnect side).
// ---------------------------------------------------------------------------
interface send_dma_if #(
  parameter int DW = pu_pkg::DW,
  parameter int PW = pu_pkg::PW
);

  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic [PW-1:0] tx_port;
  logic          tx_last;
  logic          tx_ready;

  modport master (
    output tx_valid,
    output tx_data,
    output tx_port,
    output tx_last,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    input  tx_port,
    input  tx_last,
    output tx_ready
  );

endinterface

// File: rtl/send_dma.sv
// ---------------------------------------------------------------------------
// send_dma -- reads `size` words from data memory starting at `addr` and
// streams them to destination `port` over the tx interface. Each word takes
// one read cycle, one capture cycle and at least one offer cycle.
//
// Ports:
//   clk, rst_n      clock; asynchronous active-low reset
//   start           one-cycle request; it is honoured only when the engine is idle
//   addr, size      start address and word count (unsigned, AW bits)
//   port            destination port (PW bits)
//   busy            transfer in progress. It is high from the start cycle onward
//   done            one-cycle pulse when a transfer completes
//   dm_re, dm_addr  data-memory read request
//   dm_rdata        read data. It is valid one cycle after dm_re
//   tx              send_dma_if.master word stream
//
// Build option: SEND_DMA_HDR_EN sends a header word {port, size[DW-PW-1:0]}
// before the payload. For size = 0 the header is the only word sent, and it
// is flagged last.
// ---------------------------------------------------------------------------
module send_dma #(
  parameter int DW = pu_pkg::DW,
  parameter int AW = pu_pkg::AW,
  parameter int PW = pu_pkg::PW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] addr,
  input  logic [AW-1:0] size,
  input  logic [PW-1:0] port,
  output logic          busy,
  output logic          done,
  output logic          dm_re,
  output logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_rdata,
  send_dma_if.master    tx
);

  import pu_pkg::*;

  localparam logic [AW-1:0] ONE = AW'(1);

  send_dma_state_t state_r;
  send_dma_state_t state_s;

  logic [AW-1:0] addr_r;   // address of the next word to read
  logic [AW-1:0] cnt_r;    // words still to be sent
  logic [PW-1:0] port_r;   // latched destination
  logic [DW-1:0] data_r;   // word currently offered on tx

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_s     = state_r;
    busy        = 1'b0;
    done        = 1'b0;
    dm_re       = 1'b0;
    tx.tx_valid = 1'b0;
    tx.tx_last  = 1'b0;

    case (state_r)
      IDLE: begin
        // busy rises in the start cycle so that fetch stalls immediately.
        // The reset gate keeps busy low when start is high during reset.
        busy = rst_n & start;
        if (start) begin
`ifdef SEND_DMA_HDR_EN
          state_s = HDR;
`else
          state_s = (size == '0) ? FIN : RD;
`endif
        end else begin
          state_s = IDLE;
        end
      end

`ifdef SEND_DMA_HDR_EN
      HDR: begin
        busy        = 1'b1;
        tx.tx_valid = 1'b1;
        // The header is the final word only for an empty transfer.
        tx.tx_last  = (cnt_r == '0);
        if (tx.tx_ready) begin
          state_s = (cnt_r == '0) ? FIN : RD;
        end else begin
          state_s = HDR;
        end
      end
`endif

      RD: begin
        busy    = 1'b1;
        dm_re   = 1'b1;
        state_s = CAP;
      end

      CAP: begin
        busy    = 1'b1;
        state_s = TX;
      end

      TX: begin
        busy        = 1'b1;
        tx.tx_valid = 1'b1;
        tx.tx_last  = (cnt_r == ONE);
        if (tx.tx_ready) begin
          state_s = (cnt_r == ONE) ? FIN : RD;
        end else begin
          state_s = TX;
        end
      end

      FIN: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_s = IDLE;
      end

      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Transfer bookkeeping: address, count, destination and payload registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r <= '0;
      cnt_r  <= '0;
      port_r <= '0;
      data_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            addr_r <= addr;
            cnt_r  <= size;
            port_r <= port;
`ifdef SEND_DMA_HDR_EN
            data_r <= {port, size[DW-PW-1:0]};
`endif
          end
        end
        CAP: begin
          data_r <= dm_rdata;
        end
        TX: begin
          if (tx.tx_ready) begin
            cnt_r  <= cnt_r - ONE;
            addr_r <= addr_r + ONE;  // wraps modulo 2^AW
          end
        end
        default: begin
          addr_r <= addr_r;
        end
      endcase
    end
  end

  assign dm_addr    = addr_r;
  assign tx.tx_data = data_r;
  assign tx.tx_port = port_r;

endmodule

// File: tb/tb_send_dma.sv
// ---------------------------------------------------------------------------
// tb_send_dma -- randomized self-checking bench for send_dma.
// The reference model expands each request into the list of memory addresses
// and words that must appear, and compares them with what the DUT produces.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_send_dma;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  port;
    logic        last;
  } word_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [15:0] size = 16'h0000;
  logic [3:0]  port = 4'h0;
  logic        busy, done, dm_re;
  logic [15:0] dm_addr;
  logic [15:0] dm_rdata = 16'h0000;

  send_dma_if #(.DW(16), .PW(4)) tx_if ();

  send_dma #(.DW(16), .AW(16), .PW(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .addr     (addr),
    .size     (size),
    .port     (port),
    .busy     (busy),
    .done     (done),
    .dm_re    (dm_re),
    .dm_addr  (dm_addr),
    .dm_rdata (dm_rdata),
    .tx       (tx_if.master)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory contents: fixed words at 0x10..0x12, an address hash elsewhere.
  function automatic logic [15:0] memval(input logic [15:0] a);
    logic [15:0] v;
    case (a)
      16'h0010: v = 16'hAAAA;
      16'h0011: v = 16'hBBBB;
      16'h0012: v = 16'hCCCC;
      default:  v = {a[7:0], a[15:8]} ^ 16'h3C5A;
    endcase
    return v;
  endfunction

  // Read data is valid exactly one cycle after dm_re; garbage otherwise.
  always @(posedge clk) begin
    if (dm_re) dm_rdata <= memval(dm_addr);
    else       dm_rdata <= 16'hDEAD;
  end

  word_t       exp_q[$];
  logic [15:0] addr_q[$];

  int cyc = 0;
  int mode = 0;              // 0 ready high, 1 random, 2 stall word 2, 3 ready low
  int words_seen = 0;
  int stall_cnt = 0;
  int done_cnt = 0;
  int dmre_cnt = 0;
  int first_valid_cyc = -1;
  int last_done_cyc = -1;
  bit mon_en = 1'b1;
  bit hold = 1'b0;
  word_t held;

  // Monitor and interconnect model. The DUT changes only at posedge.
  always @(negedge clk) begin
    logic  rdy;
    word_t cur;
    word_t e;
    cyc++;
    cur = {tx_if.tx_data, tx_if.tx_port, tx_if.tx_last};
    if (done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (mon_en) begin
      if (hold) begin
        check_val("stall_valid", 32'(tx_if.tx_valid), 32'd1);
        check_val("stall_word", 32'(cur), 32'(held));
      end
      if (dm_re) begin
        dmre_cnt++;
        if (addr_q.size() == 0) check_val("unexpected_dm_re", 32'(dm_addr), 32'hFFFF_FFFF);
        else check_val("dm_addr", 32'(dm_addr), 32'(addr_q.pop_front()));
      end
      case (mode)
        1:       rdy = ($urandom_range(0, 2) != 0);
        2:       rdy = !(tx_if.tx_valid && words_seen == 1 && stall_cnt < 5);
        3:       rdy = 1'b0;
        default: rdy = 1'b1;
      endcase
      if (mode == 2 && !rdy) stall_cnt++;
      if (tx_if.tx_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (tx_if.tx_valid && rdy) begin
        words_seen++;
        if (exp_q.size() == 0) check_val("unexpected_tx", 32'(cur), 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          check_val("tx_word", 32'(cur), 32'(e));
        end
        hold = 1'b0;
      end else begin
        hold = tx_if.tx_valid;
      end
      held = cur;
    end else begin
      rdy  = (mode != 3);
      hold = 1'b0;
    end
    tx_if.tx_ready = rdy;
  end

  // One transfer: build the expectation, fire start, wait for done, audit.
  task automatic run_xfer(input logic [15:0] a, input logic [15:0] s, input logic [3:0] p,
                          input int m, input bit poke);
    int    budget;
    int    start_cyc;
    int    d0;
    int    r0;
    int    exp_done;
    word_t w;
    mode = m;
    words_seen = 0;
    stall_cnt = 0;
    first_valid_cyc = -1;
`ifdef SEND_DMA_HDR_EN
    w.data = {p, s[11:0]};
    w.port = p;
    w.last = (s == 16'h0000);
    exp_q.push_back(w);
`endif
    for (int i = 0; i < int'(s); i++) begin
      logic [15:0] ai;
      ai = a + i[15:0];
      addr_q.push_back(ai);
      w.data = memval(ai);
      w.port = p;
      w.last = (i == int'(s) - 1);
      exp_q.push_back(w);
    end
    d0 = done_cnt;
    r0 = dmre_cnt;
    @(negedge clk); #1;
    addr = a; size = s; port = p; start = 1'b1;
    start_cyc = cyc;
    #1 check_val("busy_at_start", 32'(busy), 32'd1);
    @(negedge clk); #1;
    start = 1'b0;
    addr = 16'($urandom); size = 16'($urandom); port = 4'($urandom);
    budget = 0;
    while (done_cnt == d0 && budget < 40 * (int'(s) + 3)) begin
      @(negedge clk); #1;
      budget++;
      if (poke && budget == 4) begin
        start = 1'b1; addr = 16'h0300; size = 16'h0005; port = 4'hF;
        #1 check_val("busy_poke", 32'(busy), 32'd1);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check_val("done_seen", 32'(done_cnt - d0), 32'd1);
    @(negedge clk); #1;
    check_val("busy_idle", 32'(busy), 32'd0);
    check_val("done_single", 32'(done_cnt - d0), 32'd1);
    check_val("dm_re_count", 32'(dmre_cnt - r0), 32'(s));
    check_val("tx_all_sent", 32'(exp_q.size()), 32'd0);
    check_val("addr_all_read", 32'(addr_q.size()), 32'd0);
`ifdef SEND_DMA_HDR_EN
    check_val("first_valid_lat", 32'(first_valid_cyc - start_cyc), 32'd1);
    exp_done = 3 * int'(s) + 2;
`else
    if (s == 16'h0000) begin
      check_val("no_tx_valid", 32'(first_valid_cyc), 32'hFFFF_FFFF);
      exp_done = 1;   // FIN directly after the start cycle
    end else begin
      check_val("first_valid_lat", 32'(first_valid_cyc - start_cyc), 32'd3);
      exp_done = 3 * int'(s) + 1;
    end
`endif
    if (m == 0) check_val("done_latency", 32'(last_done_cyc - start_cyc), 32'(exp_done));
    exp_q.delete();
    addr_q.delete();
  endtask

  // Abort a transfer with reset while a word sits in TX.
  task automatic reset_in_tx();
    int d0;
    int waitc;
    mon_en = 1'b0;
    mode = 3;
    d0 = done_cnt;
    @(negedge clk); #1;
    addr = 16'h0040; size = 16'h0004; port = 4'h9; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    waitc = 0;
`ifdef SEND_DMA_HDR_EN
    // Accept the header so that the engine reaches a data word.
    mode = 0;
    while (!(tx_if.tx_valid && dm_addr != 16'h0040) && waitc < 20) begin
      @(negedge clk); #1;
      if (tx_if.tx_valid) mode = 3;
      waitc++;
    end
`else
    while (!tx_if.tx_valid && waitc < 20) begin
      @(negedge clk); #1;
      waitc++;
    end
`endif
    check_val("reached_tx", 32'(tx_if.tx_valid), 32'd1);
    #1 rst_n = 1'b0;
    start = 1'b1;
    #1;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_dm_re", 32'(dm_re), 32'd0);
    check_val("rst_tx_valid", 32'(tx_if.tx_valid), 32'd0);
    check_val("rst_tx_last", 32'(tx_if.tx_last), 32'd0);
    check_val("rst_dm_addr", 32'(dm_addr), 32'd0);
    check_val("rst_tx_data", 32'(tx_if.tx_data), 32'd0);
    check_val("rst_tx_port", 32'(tx_if.tx_port), 32'd0);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_val("no_done_on_abort", 32'(done_cnt - d0), 32'd0);
    check_val("idle_after_abort", 32'(busy), 32'd0);
    mode = 0;
    mon_en = 1'b1;
  endtask

  initial begin
    tx_if.tx_ready = 1'b1;
    #3;
    check_val("reset_busy", 32'(busy), 32'd0);
    check_val("reset_done", 32'(done), 32'd0);
    check_val("reset_dm_re", 32'(dm_re), 32'd0);
    check_val("reset_tx_valid", 32'(tx_if.tx_valid), 32'd0);
    check_val("reset_dm_addr", 32'(dm_addr), 32'd0);
    check_val("reset_tx_data", 32'(tx_if.tx_data), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_xfer(16'h0010, 16'd3, 4'h5, 0, 1'b0);   // AAAA, BBBB, CCCC on port 5
    run_xfer(16'h0020, 16'd0, 4'h2, 0, 1'b0);   // empty transfer
    run_xfer(16'h0100, 16'd4, 4'h3, 2, 1'b0);   // word 2 stalled 5 cycles
    run_xfer(16'hFFFF, 16'd2, 4'h7, 0, 1'b0);   // address wrap FFFF -> 0000
    run_xfer(16'h0200, 16'd3, 4'h1, 0, 1'b1);   // start while busy is ignored
    reset_in_tx();
    run_xfer(16'h0010, 16'd3, 4'h5, 0, 1'b0);   // works again after abort
    for (int k = 0; k < 12; k++) begin
      run_xfer(16'($urandom), 16'($urandom_range(0, 6)), 4'($urandom),
               int'($urandom_range(0, 1)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
